// File: rtl/at_seq_pkg.sv
// Shared types and constants for the AT command sequencer.
// ATSEQ_CRLF_APPEND_EN adds the CR/LF trailer states to the state enum.
package at_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HI,
    S_SEND_LO,
`ifdef ATSEQ_CRLF_APPEND_EN
    S_SEND_CR,
    S_SEND_LF,
`endif
    S_WAIT_RESP,
    S_DONE
  } state_t;

  localparam logic [7:0] CH_O   = 8'h4F;
  localparam logic [7:0] CH_K   = 8'h4B;
  localparam logic [7:0] CH_E   = 8'h45;
  localparam logic [7:0] CH_R   = 8'h52;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_NUL = 8'h00;

  localparam int DEF_MAX_WORDS      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/at_resp_matcher.sv
// Reply watcher: remembers the previous rx byte, spots "OK"/"ER" and
// counts cycles spent waiting so the FSM can give up on a silent module.
module at_resp_matcher
  import at_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_ok,
  output logic       o_err,
  output logic       o_expire
);

  logic [7:0]    r_prev;
  logic [TW-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev  <= CH_NUL;
      r_count <= '0;
    end else if (i_clear) begin
      r_prev  <= CH_NUL;
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TW'(1);
      if (i_rx_valid) r_prev <= i_rx_data;
    end
  end

  assign o_ok     = i_enable & i_rx_valid & (r_prev == CH_O) & (i_rx_data == CH_K);
  assign o_err    = i_enable & i_rx_valid & (r_prev == CH_E) & (i_rx_data == CH_R);
  assign o_expire = i_enable & (r_count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/at_command_sequencer.sv
// Buffers host-loaded 16-bit words and streams them to the UART TX, then waits
// for an OK/ER reply. Define ATSEQ_CRLF_APPEND_EN to append CR LF to the command.
module at_command_sequencer
  import at_seq_pkg::*;
#(
  parameter int MAX_WORDS      = DEF_MAX_WORDS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int AW = $clog2(MAX_WORDS),
  localparam int CW = $clog2(MAX_WORDS) + 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [15:0]   i_cmd_word,
  input  logic          i_start,
  input  logic          i_abort,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_resp_ok,
  output logic          o_resp_err,
  output logic          o_timeout,
  output logic          o_overflow,
  output logic [CW-1:0] o_word_count
);

  state_t        r_state, w_next;
  logic [15:0]   r_buf [MAX_WORDS];
  logic [CW-1:0] r_count, r_rd_ptr;
  logic          r_start_d, r_done, r_ok, r_err, r_timeout, r_overflow;

  logic [15:0]   w_word;
  logic [7:0]    w_byte;
  logic [CW-1:0] w_count_after;
  logic          w_idle_like, w_start_edge, w_full, w_write, w_ovf_try;
  logic          w_launch, w_empty_start, w_sending, w_skip, w_step, w_last;
  logic          w_wait, w_match_ok, w_match_err, w_expire;

  // The start seen by a launch already includes a same-cycle write.
  assign w_idle_like   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_edge  = i_start & ~r_start_d;
  assign w_full        = (r_count == CW'(MAX_WORDS));
  assign w_write       = w_idle_like & i_wr_en & ~w_full & ~i_abort;
  assign w_ovf_try     = w_idle_like & i_wr_en & w_full & ~i_abort;
  assign w_count_after = w_write ? r_count + CW'(1) : r_count;
  assign w_launch      = w_idle_like & w_start_edge & ~i_abort & (w_count_after != '0);
  assign w_empty_start = w_idle_like & w_start_edge & ~i_abort & (w_count_after == '0);

  assign w_word = r_buf[r_rd_ptr[AW-1:0]];
  assign w_last = ((r_rd_ptr + CW'(1)) == r_count);
  assign w_wait = (r_state == S_WAIT_RESP);

  always_comb begin
    w_byte    = CH_NUL;
    w_sending = 1'b0;
    case (r_state)
      S_SEND_HI: begin w_byte = w_word[15:8]; w_sending = 1'b1; end
      S_SEND_LO: begin w_byte = w_word[7:0];  w_sending = 1'b1; end
`ifdef ATSEQ_CRLF_APPEND_EN
      S_SEND_CR: begin w_byte = CH_CR; w_sending = 1'b1; end
      S_SEND_LF: begin w_byte = CH_LF; w_sending = 1'b1; end
`endif
      default: begin w_byte = CH_NUL; w_sending = 1'b0; end
    endcase
  end

  // NUL data bytes pad odd-length commands and are dropped without a handshake.
  assign w_skip     = ((r_state == S_SEND_HI) || (r_state == S_SEND_LO)) && (w_byte == CH_NUL);
  assign o_tx_valid = w_sending & ~w_skip;
  assign o_tx_data  = w_byte;
  assign w_step     = (o_tx_valid & i_tx_ready) | w_skip;

  at_resp_matcher #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_matcher (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_enable  (w_wait),
    .i_clear   (~w_wait),
    .i_rx_data (i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_ok      (w_match_ok),
    .o_err     (w_match_err),
    .o_expire  (w_expire)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_launch)           w_next = S_SEND_HI;
        else if (w_empty_start) w_next = S_DONE;
      end
      S_SEND_HI: if (w_step) w_next = S_SEND_LO;
      S_SEND_LO: begin
        if (w_step) begin
`ifdef ATSEQ_CRLF_APPEND_EN
          w_next = w_last ? S_SEND_CR : S_SEND_HI;
`else
          w_next = w_last ? S_WAIT_RESP : S_SEND_HI;
`endif
        end
      end
`ifdef ATSEQ_CRLF_APPEND_EN
      S_SEND_CR: if (w_step) w_next = S_SEND_LF;
      S_SEND_LF: if (w_step) w_next = S_WAIT_RESP;
`endif
      S_WAIT_RESP: if (w_match_ok | w_match_err | w_expire) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  always_ff @(posedge i_clock) begin
    if (w_write) r_buf[r_count[AW-1:0]] <= i_cmd_word;
  end

  // Abort drops the buffer but deliberately leaves the sticky result flags alone.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_start_d  <= 1'b0;
      r_done     <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_start_d <= i_start;
      if (i_abort) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_write)   r_count    <= w_count_after;
        if (w_ovf_try) r_overflow <= 1'b1;
        if (w_launch) begin
          r_done    <= 1'b0;
          r_ok      <= 1'b0;
          r_err     <= 1'b0;
          r_timeout <= 1'b0;
          r_rd_ptr  <= '0;
        end
        if (w_empty_start) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end
        if ((r_state == S_SEND_LO) && w_step) r_rd_ptr <= r_rd_ptr + CW'(1);
        if (w_wait) begin
          if (w_match_ok)       r_ok <= 1'b1;
          else if (w_match_err) r_err <= 1'b1;
          else if (w_expire) begin
            r_timeout <= 1'b1;
            r_err     <= 1'b1;
          end
          if (w_match_ok | w_match_err | w_expire) begin
            r_done  <= 1'b1;
            r_count <= '0;
          end
        end
      end
    end
  end

  assign o_busy       = ~w_idle_like;
  assign o_done       = r_done;
  assign o_resp_ok    = r_ok;
  assign o_resp_err   = r_err;
  assign o_timeout    = r_timeout;
  assign o_overflow   = r_overflow;
  assign o_word_count = r_count;

endmodule

// File: tb/tb_at_command_sequencer.sv
// Bench for at_command_sequencer: a table of per-cycle vectors plus directed
// sequences for full commands, abort, overflow/timeout and async reset.
module tb_at_command_sequencer;

   localparam int TMO = 40;

   logic        clock;
   logic        reset;
   logic        wrEn;
   logic [15:0] cmdWord;
   logic        start;
   logic        abort;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        busy;
   logic        done;
   logic        respOk;
   logic        respErr;
   logic        timeoutFlag;
   logic        overflow;
   logic [4:0]  wordCount;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic        wr;
      logic [15:0] word;
      logic        start;
      logic        abort;
      logic        rdy;
      logic        rxv;
      logic [7:0]  rxd;
      logic        busy;
      logic        done;
      logic        ok;
      logic        err;
      logic [4:0]  cnt;
      logic        txv;
      logic [7:0]  txd;
   } vec_t;

   vec_t        vecs[$];
   logic [7:0]  gotBytes[$];
   int          gotCycles[$];
   logic [7:0]  expBytes[$];

   at_command_sequencer #(.MAX_WORDS(16), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clock     (clock),
      .i_reset     (reset),
      .i_wr_en     (wrEn),
      .i_cmd_word  (cmdWord),
      .i_start     (start),
      .i_abort     (abort),
      .o_tx_data   (txData),
      .o_tx_valid  (txValid),
      .i_tx_ready  (txReady),
      .i_rx_data   (rxData),
      .i_rx_valid  (rxValid),
      .o_busy      (busy),
      .o_done      (done),
      .o_resp_ok   (respOk),
      .o_resp_err  (respErr),
      .o_timeout   (timeoutFlag),
      .o_overflow  (overflow),
      .o_word_count(wordCount)
   );

   // Free-running clock; inputs change and outputs are sampled 1 unit after the rising edge.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic stepClock;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void addVec(input logic wr, input logic [15:0] word, input logic st,
                                  input logic ab, input logic rdy, input logic rxv,
                                  input logic [7:0] rxd, input logic eBusy, input logic eDone,
                                  input logic eOk, input logic eErr, input logic [4:0] eCnt,
                                  input logic eTxv, input logic [7:0] eTxd);
      vec_t v;
      v.wr = wr; v.word = word; v.start = st; v.abort = ab; v.rdy = rdy;
      v.rxv = rxv; v.rxd = rxd; v.busy = eBusy; v.done = eDone; v.ok = eOk;
      v.err = eErr; v.cnt = eCnt; v.txv = eTxv; v.txd = eTxd;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input vec_t v);
      wrEn    = v.wr;
      cmdWord = v.word;
      start   = v.start;
      abort   = v.abort;
      txReady = v.rdy;
      rxValid = v.rxv;
      rxData  = v.rxd;
      stepClock();
   endtask

   task automatic verifyVector(input int i, input vec_t v);
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(v.busy));
      checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(v.done));
      checkOutput($sformatf("vec%0d resp_ok", i), 32'(respOk), 32'(v.ok));
      checkOutput($sformatf("vec%0d resp_err", i), 32'(respErr), 32'(v.err));
      checkOutput($sformatf("vec%0d word_count", i), 32'(wordCount), 32'(v.cnt));
      checkOutput($sformatf("vec%0d tx_valid", i), 32'(txValid), 32'(v.txv));
      if (v.txv) checkOutput($sformatf("vec%0d tx_data", i), 32'(txData), 32'(v.txd));
      checkOutput($sformatf("vec%0d timeout", i), 32'(timeoutFlag), 32'(0));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " tx_data"}, 32'(txData), 32'(0));
      checkOutput({tag, " tx_valid"}, 32'(txValid), 32'(0));
      checkOutput({tag, " busy"}, 32'(busy), 32'(0));
      checkOutput({tag, " done"}, 32'(done), 32'(0));
      checkOutput({tag, " resp_ok"}, 32'(respOk), 32'(0));
      checkOutput({tag, " resp_err"}, 32'(respErr), 32'(0));
      checkOutput({tag, " timeout"}, 32'(timeoutFlag), 32'(0));
      checkOutput({tag, " overflow"}, 32'(overflow), 32'(0));
      checkOutput({tag, " word_count"}, 32'(wordCount), 32'(0));
   endtask

   task automatic loadWord(input logic [15:0] w);
      wrEn    = 1'b1;
      cmdWord = w;
      stepClock();
      wrEn    = 1'b0;
   endtask

   task automatic startCmd;
      start = 1'b1;
      stepClock();
      start = 1'b0;
   endtask

   // Records every accepted byte and the cycle it was accepted in, up to n bytes or the budget.
   task automatic collectBytes(input string tag, input int n, input int budget);
      gotBytes.delete();
      gotCycles.delete();
      txReady = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (txValid && txReady) begin
            gotBytes.push_back(txData);
            gotCycles.push_back(c);
         end
         stepClock();
         if (gotBytes.size() == n) break;
      end
      checkOutput({tag, " byte count"}, 32'(gotBytes.size()), 32'(n));
   endtask

   task automatic checkBytes(input string tag);
      for (int i = 0; i < gotBytes.size() && i < expBytes.size(); i++)
         checkOutput($sformatf("%s byte%0d", tag, i), 32'(gotBytes[i]), 32'(expBytes[i]));
      if (gotBytes.size() > 0)
         checkOutput({tag, " one byte per cycle"},
                     32'(gotCycles[gotCycles.size()-1] - gotCycles[0]), 32'(gotBytes.size() - 1));
   endtask

   initial begin
      int waited;
      int extra;

      wrEn = 0; cmdWord = 0; start = 0; abort = 0; txReady = 0; rxData = 0; rxValid = 0;
      reset = 1'b1;
      stepClock();
      stepClock();
      checkAllZero("reset");
      reset = 1'b0;
      stepClock();

      // Empty start, then "AT"+"K\0" with 1-in-3 tx_ready, ERROR reply, abort-vs-write priority.
      addVec(0, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00);
      addVec(1, 16'h4154, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 1, 0, 8'h00);
      addVec(1, 16'h4B00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 2, 0, 8'h00);
      addVec(0, 16'h0000, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h41);
      addVec(0, 16'h0000, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h41);
      addVec(0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h41);
      addVec(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h54);
      addVec(0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h54);
      addVec(0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h54);
      addVec(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h4B);
      addVec(0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h4B);
      addVec(0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h4B);
      addVec(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 2, 0, 8'h00);
`ifdef ATSEQ_CRLF_APPEND_EN
      addVec(0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h0D);
      addVec(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 2, 1, 8'h0A);
      addVec(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 2, 0, 8'h00);
`else
      addVec(0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 0, 8'h00);
`endif
      addVec(0, 16'h0000, 0, 0, 0, 1, 8'h45, 1, 0, 0, 0, 2, 0, 8'h00);
      addVec(0, 16'h0000, 0, 0, 0, 1, 8'h52, 0, 1, 0, 1, 0, 0, 8'h00);
      addVec(0, 16'h0000, 0, 0, 0, 1, 8'h52, 0, 1, 0, 1, 0, 0, 8'h00);
      addVec(0, 16'h0000, 0, 0, 0, 1, 8'h4F, 0, 1, 0, 1, 0, 0, 8'h00);
      addVec(0, 16'h0000, 0, 0, 0, 1, 8'h52, 0, 1, 0, 1, 0, 0, 8'h00);
      addVec(0, 16'h0000, 0, 0, 0, 1, 8'h4F, 0, 1, 0, 1, 0, 0, 8'h00);
      addVec(0, 16'h0000, 0, 0, 0, 1, 8'h4B, 0, 1, 0, 1, 0, 0, 8'h00);
      addVec(1, 16'h1234, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 1, 0, 8'h00);
      addVec(1, 16'h5678, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         verifyVector(i, vecs[i]);
      end
      wrEn = 0; start = 0; abort = 0; txReady = 0; rxValid = 0; rxData = 0;
      stepClock();

      // Full "AT+NAME=OP" command with an OK reply.
      loadWord(16'h4154); loadWord(16'h2B4E); loadWord(16'h414D);
      loadWord(16'h453D); loadWord(16'h4F50);
      expBytes = '{8'h41, 8'h54, 8'h2B, 8'h4E, 8'h41, 8'h4D, 8'h45, 8'h3D, 8'h4F, 8'h50};
`ifdef ATSEQ_CRLF_APPEND_EN
      expBytes.push_back(8'h0D);
      expBytes.push_back(8'h0A);
`endif
      startCmd();
      collectBytes("name", expBytes.size(), 60);
      checkBytes("name");
      checkOutput("name tx_valid after last", 32'(txValid), 32'(0));
      rxValid = 1'b1; rxData = 8'h4F; stepClock();
      rxData = 8'h4B; stepClock();
      rxValid = 1'b0;
      checkOutput("name resp_ok", 32'(respOk), 32'(1));
      checkOutput("name resp_err", 32'(respErr), 32'(0));
      checkOutput("name done", 32'(done), 32'(1));
      checkOutput("name word_count", 32'(wordCount), 32'(0));
      checkOutput("name busy", 32'(busy), 32'(0));

      // Abort after three bytes have gone out.
      loadWord(16'h4154); loadWord(16'h2B4E);
      startCmd();
      collectBytes("abort", 3, 20);
      txReady = 1'b0; abort = 1'b1;
      stepClock();
      abort = 1'b0;
      checkOutput("abort tx_valid", 32'(txValid), 32'(0));
      checkOutput("abort busy", 32'(busy), 32'(0));
      checkOutput("abort word_count", 32'(wordCount), 32'(0));
      checkOutput("abort done", 32'(done), 32'(0));
      txReady = 1'b1;
      extra = 0;
      repeat (6) begin
         if (txValid) extra++;
         stepClock();
      end
      checkOutput("abort no further bytes", 32'(extra), 32'(0));
      txReady = 1'b0;

      // Sixteen words, an overflowing 17th, then silence until timeout.
      expBytes.delete();
      for (int i = 0; i < 16; i++) begin
         loadWord({8'(8'h41 + i), 8'(8'h61 + i)});
         expBytes.push_back(8'(8'h41 + i));
         expBytes.push_back(8'(8'h61 + i));
      end
`ifdef ATSEQ_CRLF_APPEND_EN
      expBytes.push_back(8'h0D);
      expBytes.push_back(8'h0A);
`endif
      checkOutput("full word_count", 32'(wordCount), 32'(16));
      checkOutput("full overflow before", 32'(overflow), 32'(0));
      loadWord(16'h5A5A);
      checkOutput("ovf overflow", 32'(overflow), 32'(1));
      checkOutput("ovf word_count", 32'(wordCount), 32'(16));
      startCmd();
      collectBytes("full", expBytes.size(), 120);
      checkBytes("full");
      waited = 0;
      while (!done && waited < TMO + 10) begin
         stepClock();
         waited++;
      end
      checkOutput("timeout latency", 32'(waited), 32'(TMO));
      checkOutput("timeout flag", 32'(timeoutFlag), 32'(1));
      checkOutput("timeout resp_err", 32'(respErr), 32'(1));
      checkOutput("timeout resp_ok", 32'(respOk), 32'(0));
      checkOutput("timeout word_count", 32'(wordCount), 32'(0));
      checkOutput("timeout overflow kept", 32'(overflow), 32'(1));

      // Asynchronous reset while waiting for a reply.
      loadWord(16'h4154);
      startCmd();
`ifdef ATSEQ_CRLF_APPEND_EN
      collectBytes("rst", 4, 20);
`else
      collectBytes("rst", 2, 20);
`endif
      rxValid = 1'b1; rxData = 8'h4F; stepClock();
      rxValid = 1'b0;
      checkOutput("rst busy before", 32'(busy), 32'(1));
      #3 reset = 1'b1;
      #1;
      checkAllZero("async reset");
      stepClock();
      reset = 1'b0;
      stepClock();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
